// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: circular FIFO feeding a UART transmitter one frame at a time.
// Bytes written by the host are queued. A two-state FSM pops the head and pulses
// tx_start with din held. It then waits for tx_done_tick before launching the next byte.
// Optional feature macro: UART_TX_FEEDER_LEVEL_EN adds the `level` occupancy port.
module uart_tx_feeder #(
    parameter int W      = 8,
    parameter int ADDR_W = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr,
    input  logic [W-1:0]  w_data,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    input  logic          tx_done_tick,
    output logic          tx_start,
    output logic [W-1:0]  din,
    output logic          tx_busy
`ifdef UART_TX_FEEDER_LEVEL_EN
    ,
    output logic [ADDR_W:0] level
`endif
);

    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    logic [W-1:0]      mem_q [2**ADDR_W];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              overflow_q, overflow_d;
    state_t            state_q;
    logic              tx_start_q;
    logic [W-1:0]      din_q;
    logic              wr_accept_s;
    logic              pop_s;

    // Next-state logic for the FIFO: accept and pop decisions, pointers, count and flags.
    always_comb begin
        wr_accept_s = wr && !full_q;
        pop_s       = (state_q == ST_IDLE) && !empty_q;
        overflow_d  = wr && full_q;

        if (wr_accept_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // A simultaneous write and pop leaves the occupancy unchanged.
        case ({wr_accept_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == CNT_ZERO);
    end

    // FIFO storage: the byte is written at the tail on every accepted write.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem_q[wr_ptr_q] <= w_data;
        end
    end

    // FIFO bookkeeping registers: pointers, occupancy, and the registered flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= {ADDR_W{1'b0}};
            rd_ptr_q   <= {ADDR_W{1'b0}};
            count_q    <= CNT_ZERO;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // Launch FSM: pop the head when idle, pulse tx_start, and hold din until the frame completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            tx_start_q <= 1'b0;
            din_q      <= {W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty_q) begin
                        din_q      <= mem_q[rd_ptr_q];
                        tx_start_q <= 1'b1;
                        state_q    <= ST_BUSY;
                    end else begin
                        tx_start_q <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    tx_start_q <= 1'b0;
                    if (tx_done_tick) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_BUSY;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    tx_start_q <= 1'b0;
                end
            endcase
        end
    end

    assign full     = full_q;
    assign empty    = empty_q;
    assign overflow = overflow_q;
    assign tx_start = tx_start_q;
    assign din      = din_q;
    assign tx_busy  = (state_q == ST_BUSY);
`ifdef UART_TX_FEEDER_LEVEL_EN
    assign level    = count_q;
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Testbench for uart_tx_feeder: random and directed stimulus checked against a
// queue-based behavioural model of the buffer and the one-frame-at-a-time launcher.
module tb_uart_tx_feeder;

    logic       clk;
    logic       reset_n;
    logic       wr;
    logic [7:0] w_data;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       tx_done_tick;
    logic       tx_start;
    logic [7:0] din;
    logic       tx_busy;
`ifdef UART_TX_FEEDER_LEVEL_EN
    logic [4:0] level;
`endif

    uart_tx_feeder #(.W(8), .ADDR_W(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr           (wr),
        .w_data       (w_data),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .tx_done_tick (tx_done_tick),
        .tx_start     (tx_start),
        .din          (din),
        .tx_busy      (tx_busy)
`ifdef UART_TX_FEEDER_LEVEL_EN
        ,
        .level        (level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of pending bytes, a frame-in-flight flag, and the last outputs.
    logic [7:0] mq[$];
    bit         m_busy = 1'b0;
    bit         m_start = 1'b0;
    bit         m_ovf = 1'b0;
    logic [7:0] m_din = 8'h00;

    function automatic logic [12:0] exp_vec();
        return {m_start, m_din, (mq.size() == 16), (mq.size() == 0), m_ovf, m_busy};
    endfunction

    function automatic logic [12:0] obs_vec();
        return {tx_start, din, full, empty, overflow, tx_busy};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_busy  = 1'b0;
        m_start = 1'b0;
        m_ovf   = 1'b0;
        m_din   = 8'h00;
    endtask

    // Drive one clock cycle of inputs, then advance the model by that cycle.
    task automatic step(input bit w, input logic [7:0] d, input bit done);
        bit pop;
        bit pre_busy;
        @(negedge clk);
        wr = w;
        w_data = d;
        tx_done_tick = done;
        @(posedge clk);
        #1;
        pre_busy = m_busy;
        pop      = !m_busy && (mq.size() > 0);
        m_ovf    = w && (mq.size() == 16);
        if (pop) begin
            m_din   = mq.pop_front();
            m_start = 1'b1;
        end else begin
            m_start = 1'b0;
        end
        if (pre_busy && done) m_busy = 1'b0;
        if (pop) m_busy = 1'b1;
        if (w && !m_ovf) mq.push_back(d);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wr = 1'b0;
        w_data = 8'h00;
        tx_done_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b want 0", tx_start); end
        checks++; if (din !== 8'h00) begin errors++; $display("FAIL reset_din got %h want 00", din); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy got %b want 0", tx_busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
`ifdef UART_TX_FEEDER_LEVEL_EN
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
`endif
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        step(1'b1, 8'hA5, 1'b0);
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL single_early_start got %b want 0", tx_start); end
        step(1'b0, 8'h00, 1'b0);
        checks++; if (tx_start !== 1'b1 || din !== 8'hA5) begin
            errors++; $display("FAIL single_launch got start=%b din=%h want start=1 din=a5", tx_start, din);
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty got %b want 1", empty); end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, (i == 7));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL single_busy cyc %0d got %h want %h", i, obs_vec(), exp_vec());
            end
            if (i < 7) begin
                checks++; if (tx_busy !== 1'b1 || tx_start !== 1'b0) begin
                    errors++; $display("FAIL single_hold got busy=%b start=%b want busy=1 start=0", tx_busy, tx_start);
                end
            end
        end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL single_done got busy=%b want 0", tx_busy); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL fill cyc %0d got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        checks++; if (full !== 1'b0 || empty !== 1'b0) begin
            errors++; $display("FAIL fill_15 got full=%b empty=%b want full=0 empty=0", full, empty);
        end
`ifdef UART_TX_FEEDER_LEVEL_EN
        checks++; if (level !== 5'd15) begin errors++; $display("FAIL fill_level got %0d want 15", level); end
`endif
        step(1'b1, 8'($urandom), 1'b0);
        checks++; if (full !== 1'b1 || overflow !== 1'b0) begin
            errors++; $display("FAIL fill_full got full=%b ovf=%b want full=1 ovf=0", full, overflow);
        end
        step(1'b1, 8'($urandom), 1'b0);
        checks++; if (overflow !== 1'b1 || full !== 1'b1) begin
            errors++; $display("FAIL fill_overflow got ovf=%b full=%b want ovf=1 full=1", overflow, full);
        end
        step(1'b0, 8'h00, 1'b0);
        checks++; if (obs_vec() !== exp_vec() || overflow !== 1'b0) begin
            errors++; $display("FAIL fill_ovf_pulse got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_drain();
        int since = 0;
        int launches = 0;
        bool_loop: for (int c = 0; c < 400; c++) begin
            bit done;
            bit done_prev;
            done_prev = 1'b0;
            done = m_busy && (since == 10);
            step(1'b0, 8'h00, done);
            if (m_start) since = 0; else since++;
            if (tx_start === 1'b1) launches++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL drain cyc %0d got %h want %h", c, obs_vec(), exp_vec());
            end
            if (mq.size() == 0 && !m_busy) break;
        end
        checks++; if (launches !== 16) begin errors++; $display("FAIL drain_launches got %0d want 16", launches); end
        checks++; if (empty !== 1'b1 || tx_busy !== 1'b0) begin
            errors++; $display("FAIL drain_end got empty=%b busy=%b want empty=1 busy=0", empty, tx_busy);
        end
    endtask

    task automatic test_back_to_back();
        // Tick done in the cycle right after each launch; the next launch must follow 2 cycles later.
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0);
        for (int c = 0; c < 40; c++) begin
            bit done;
            done = m_busy && !m_start;
            step(1'b0, 8'h00, done);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL b2b cyc %0d got %h want %h", c, obs_vec(), exp_vec());
            end
            if (mq.size() == 0 && !m_busy) break;
        end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL b2b_end got busy=%b want 0", tx_busy); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'b0);
        checks++; if (tx_busy !== 1'b1 || empty !== 1'b0) begin
            errors++; $display("FAIL mid_pre got busy=%b empty=%b want busy=1 empty=0", tx_busy, empty);
        end
        @(negedge clk);
        wr = 1'b0;
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++; if (empty !== 1'b1 || tx_busy !== 1'b0 || tx_start !== 1'b0 || full !== 1'b0) begin
            errors++; $display("FAIL mid_reset got empty=%b busy=%b start=%b full=%b want 1 0 0 0",
                               empty, tx_busy, tx_start, full);
        end
`ifdef UART_TX_FEEDER_LEVEL_EN
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL mid_level got %0d want 0", level); end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 8'h00, 1'b0);
            checks++;
            if (tx_start !== 1'b0 || obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL mid_after cyc %0d got %h want %h", c, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_idle_done();
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 8'h00, 1'b1);
            checks++;
            if (tx_start !== 1'b0 || tx_busy !== 1'b0 || empty !== 1'b1) begin
                errors++; $display("FAIL idle_done cyc %0d got start=%b busy=%b empty=%b want 0 0 1",
                                   c, tx_start, tx_busy, empty);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random cyc %0d got %h want %h", c, obs_vec(), exp_vec());
            end
`ifdef UART_TX_FEEDER_LEVEL_EN
            checks++;
            if (level !== 5'(mq.size())) begin
                errors++; $display("FAIL random_level cyc %0d got %0d want %0d", c, level, mq.size());
            end
`endif
        end
        for (int c = 0; c < 200; c++) begin
            if (mq.size() == 0 && !m_busy) break;
            step(1'b0, 8'h00, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL random_drain cyc %0d got %h want %h", c, obs_vec(), exp_vec());
            end
        end
        checks++; if (empty !== 1'b1 || tx_busy !== 1'b0) begin
            errors++; $display("FAIL random_end got empty=%b busy=%b want 1 0", empty, tx_busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_drain();
        test_back_to_back();
        test_reset_mid();
        test_idle_done();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
